// File: rtl/coefficient_rle_encoder_pkg.sv
// Shared constants and state encoding for the JPEG coefficient run-length encoder.
// Symbol fields that depend on COEF_WIDTH are built inside the top module.
package coef_rle_pkg;

  localparam logic [3:0] ZRL_RUN  = 4'd15;
  localparam logic [3:0] EOB_RUN  = 4'd0;
  localparam int         EOB_SIZE = 0;

  typedef enum logic [1:0] {
    S_DC  = 2'd0,
    S_AC  = 2'd1,
    S_ZRL = 2'd2
  } state_e;

endpackage

// File: rtl/coefficient_rle_encoder_if.sv
// Coefficient input stream and (run, size, amplitude) symbol output stream.
// The encoder uses the slave modport; the producer/consumer side uses master.
interface coefficient_rle_encoder_if #(
  parameter int COEF_WIDTH   = 16,
  parameter int NUM_CHANNELS = 3
);
  localparam int CH_WIDTH   = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam int SIZE_WIDTH = $clog2(COEF_WIDTH + 2);

  logic signed [COEF_WIDTH-1:0] coef_in;
  logic [CH_WIDTH-1:0]          coef_channel;
  logic                         coef_valid;
  logic                         coef_ready;
  logic [3:0]                   sym_run;
  logic [SIZE_WIDTH-1:0]        sym_size;
  logic [COEF_WIDTH:0]          sym_amplitude;
  logic                         sym_is_dc;
  logic                         sym_last;
  logic                         sym_valid;
  logic                         sym_ready;

  modport slave (
    input  coef_in, coef_channel, coef_valid, sym_ready,
    output coef_ready, sym_run, sym_size, sym_amplitude, sym_is_dc, sym_last, sym_valid
  );

  modport master (
    output coef_in, coef_channel, coef_valid, sym_ready,
    input  coef_ready, sym_run, sym_size, sym_amplitude, sym_is_dc, sym_last, sym_valid
  );

endinterface

// File: rtl/coefficient_rle_encoder_magnitude_category.sv
// Combinational JPEG magnitude category: signed value -> (size, amplitude bits).
// Negative values use the one's-complement style amplitude, i.e. (v - 1) masked to size bits.
module magnitude_category #(
  parameter int W  = 17,
  parameter int SW = $clog2(W + 1)
) (
  input  logic signed [W-1:0] value_i,
  output logic [SW-1:0]       size_o,
  output logic [W-1:0]        amp_o
);

  logic [W-1:0] mag;
  logic [W-1:0] vm1;
  logic [W-1:0] mask;

  always_comb begin
    mag    = value_i[W-1] ? $unsigned(-value_i) : $unsigned(value_i);
    vm1    = $unsigned(value_i) - W'(1);
    size_o = '0;
    for (int i = 0; i < W; i++) begin
      if (mag[i]) size_o = SW'(i + 1);
    end
    mask = '0;
    for (int i = 0; i < W; i++) begin
      mask[i] = (SW'(i) < size_o);
    end
    amp_o = (value_i[W-1] ? vm1 : $unsigned(value_i)) & mask;
  end

endmodule

// File: rtl/coefficient_rle_encoder.sv
// Zigzag-ordered coefficient stream to T.81 (run, size, amplitude) symbols with DC
// prediction per channel, AC zero-run coding, ZRL and EOB insertion; one output register.
module coefficient_rle_encoder
  import coef_rle_pkg::*;
#(
  parameter int COEF_WIDTH   = 16,
  parameter int NUM_CHANNELS = 3,
  parameter int BLOCK_LEN    = 64
) (
  input logic                     clock,
  input logic                     reset,
  input logic                     restart,
  coefficient_rle_encoder_if.slave bus
);

  localparam int CH_WIDTH   = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam int SIZE_WIDTH = $clog2(COEF_WIDTH + 2);
  localparam int DIFF_W     = COEF_WIDTH + 1;
  localparam int IDX_W      = (BLOCK_LEN > 2) ? $clog2(BLOCK_LEN) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BLOCK_LEN - 1);

  typedef struct packed {
    logic [3:0]            run;
    logic [SIZE_WIDTH-1:0] size;
    logic [DIFF_W-1:0]     amp;
    logic                  is_dc;
    logic                  last;
  } sym_t;

  function automatic sym_t mk_sym(input logic [3:0] run, input logic [SIZE_WIDTH-1:0] size,
                                  input logic [DIFF_W-1:0] amp, input logic is_dc,
                                  input logic last);
    sym_t s;
    s.run   = run;
    s.size  = size;
    s.amp   = amp;
    s.is_dc = is_dc;
    s.last  = last;
    return s;
  endfunction

  state_e                       state_q, state_d;
  logic [IDX_W-1:0]             idx_q, idx_d;
  logic [IDX_W-1:0]             zrun_q, zrun_d;
  logic [IDX_W-1:0]             zcnt_q, zcnt_d;
  logic signed [COEF_WIDTH-1:0] hold_q, hold_d;
  logic [3:0]                   hrun_q, hrun_d;
  logic                         hlast_q, hlast_d;
  logic                         val_q, val_d;
  sym_t                         sym_q, sym_d;
  logic signed [COEF_WIDTH-1:0] pred_q [NUM_CHANNELS];

  logic                         coef_ready;
  logic                         out_free;
  logic                         accept;
  logic                         dc_accept;
  logic                         is_last_idx;
  logic [IDX_W-1:0]             idx_next;
  logic signed [COEF_WIDTH-1:0] pred_sel;
  logic signed [DIFF_W-1:0]     diff;
  logic signed [DIFF_W-1:0]     cat_in;
  logic [SIZE_WIDTH-1:0]        cat_size;
  logic [DIFF_W-1:0]            cat_amp;

  assign out_free    = !val_q || bus.sym_ready;
  assign coef_ready  = (state_q != S_ZRL) && out_free;
  assign accept      = bus.coef_valid && coef_ready;
  assign dc_accept   = accept && (state_q == S_DC);
  assign is_last_idx = (idx_q == LAST_IDX);
  assign idx_next    = is_last_idx ? '0 : idx_q + IDX_W'(1);

  // A restart in the same cycle as the DC accept predicts from zero.
  always_comb begin
    pred_sel = '0;
    if (!restart) begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        if (bus.coef_channel == CH_WIDTH'(c)) pred_sel = pred_q[c];
      end
    end
  end

  assign diff = {bus.coef_in[COEF_WIDTH-1], bus.coef_in} - {pred_sel[COEF_WIDTH-1], pred_sel};

  always_comb begin
    if (state_q == S_ZRL)     cat_in = {hold_q[COEF_WIDTH-1], hold_q};
    else if (state_q == S_DC) cat_in = diff;
    else                      cat_in = {bus.coef_in[COEF_WIDTH-1], bus.coef_in};
  end

  magnitude_category #(.W(DIFF_W), .SW(SIZE_WIDTH)) u_cat (
    .value_i (cat_in),
    .size_o  (cat_size),
    .amp_o   (cat_amp)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    zrun_d  = zrun_q;
    zcnt_d  = zcnt_q;
    hold_d  = hold_q;
    hrun_d  = hrun_q;
    hlast_d = hlast_q;
    val_d   = val_q && !bus.sym_ready;
    sym_d   = sym_q;
    case (state_q)
      S_DC: begin
        if (accept) begin
          sym_d   = mk_sym(4'd0, cat_size, cat_amp, 1'b1, 1'b0);
          val_d   = 1'b1;
          idx_d   = idx_next;
          zrun_d  = '0;
          state_d = S_AC;
        end
      end
      S_AC: begin
        if (accept) begin
          idx_d = idx_next;
          if (bus.coef_in == '0) begin
            if (is_last_idx) begin
              // Trailing zeros collapse into EOB; any whole-16 runs are dropped.
              sym_d   = mk_sym(EOB_RUN, SIZE_WIDTH'(EOB_SIZE), '0, 1'b0, 1'b1);
              val_d   = 1'b1;
              zrun_d  = '0;
              state_d = S_DC;
            end else begin
              zrun_d = zrun_q + IDX_W'(1);
            end
          end else if (int'(zrun_q) >= 16) begin
            // First ZRL goes out now; the coefficient waits in the hold register.
            hold_d  = bus.coef_in;
            hrun_d  = 4'(zrun_q);
            hlast_d = is_last_idx;
            zcnt_d  = IDX_W'((int'(zrun_q) >> 4) - 1);
            sym_d   = mk_sym(ZRL_RUN, '0, '0, 1'b0, 1'b0);
            val_d   = 1'b1;
            zrun_d  = '0;
            state_d = S_ZRL;
          end else begin
            sym_d   = mk_sym(4'(zrun_q), cat_size, cat_amp, 1'b0, is_last_idx);
            val_d   = 1'b1;
            zrun_d  = '0;
            state_d = is_last_idx ? S_DC : S_AC;
          end
        end
      end
      S_ZRL: begin
        if (out_free) begin
          val_d = 1'b1;
          if (zcnt_q != '0) begin
            sym_d  = mk_sym(ZRL_RUN, '0, '0, 1'b0, 1'b0);
            zcnt_d = zcnt_q - IDX_W'(1);
          end else begin
            sym_d   = mk_sym(hrun_q, cat_size, cat_amp, 1'b0, hlast_q);
            state_d = hlast_q ? S_DC : S_AC;
          end
        end
      end
      default: state_d = S_DC;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_DC;
      idx_q   <= '0;
      zrun_q  <= '0;
      zcnt_q  <= '0;
      hold_q  <= '0;
      hrun_q  <= '0;
      hlast_q <= 1'b0;
      val_q   <= 1'b0;
      sym_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      zrun_q  <= zrun_d;
      zcnt_q  <= zcnt_d;
      hold_q  <= hold_d;
      hrun_q  <= hrun_d;
      hlast_q <= hlast_d;
      val_q   <= val_d;
      sym_q   <= sym_d;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < NUM_CHANNELS; c++) pred_q[c] <= '0;
    end else begin
      if (restart) begin
        for (int c = 0; c < NUM_CHANNELS; c++) pred_q[c] <= '0;
      end
      if (dc_accept) begin
        for (int c = 0; c < NUM_CHANNELS; c++) begin
          if (bus.coef_channel == CH_WIDTH'(c)) pred_q[c] <= bus.coef_in;
        end
      end
    end
  end

  assign bus.coef_ready    = coef_ready;
  assign bus.sym_valid     = val_q;
  assign bus.sym_run       = sym_q.run;
  assign bus.sym_size      = sym_q.size;
  assign bus.sym_amplitude = sym_q.amp;
  assign bus.sym_is_dc     = sym_q.is_dc;
  assign bus.sym_last      = sym_q.last;

endmodule

// File: doc/coefficient_rle_encoder.md
# coefficient_rle_encoder

- Streaming JPEG entropy-coding front end; sits between the zigzag reorder buffer and the Huffman lookup/bit packer.
- Per 8x8 block it accepts one quantised coefficient per handshake, in zigzag order.
- It emits (run, size, amplitude) symbols per ITU-T T.81 F.1.2: DC differential coding with per-channel predictors, AC zero-run coding, ZRL and EOB insertion.
- Generalised over coefficient width, block length and channel count; fully handshaked on both sides.

## Interface
Parameters:
- COEF_WIDTH, 16, signed input coefficient width.
- NUM_CHANNELS, 3, number of independent DC predictors (colour components).
- BLOCK_LEN, 64, coefficients per block (index 0 is DC).
- CH_WIDTH, derived = max(1, clog2(NUM_CHANNELS)).
- SIZE_WIDTH, derived = clog2(COEF_WIDTH+2).

Ports (one clock; reset is asynchronous and active-high):
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high; clears all state.
- restart  in  1  one-cycle pulse; zeroes all DC predictors (restart marker).
- coef_in  in  COEF_WIDTH  signed coefficient.
- coef_channel  in  CH_WIDTH  component index; sampled only at index 0.
- coef_valid  in  1  coefficient present.
- coef_ready  out  1  block can accept this cycle.
- sym_run  out  4  preceding zero run (0..15).
- sym_size  out  SIZE_WIDTH  magnitude category; 0 for EOB or ZRL.
- sym_amplitude  out  COEF_WIDTH+1  low sym_size bits are valid; upper bits zero.
- sym_is_dc  out  1  symbol is a DC difference.
- sym_last  out  1  final symbol of the block.
- sym_valid  out  1  symbol present.
- sym_ready  in  1  downstream accepts.

## Operation
- Category/amplitude of a value v: size = bit position of the MSB of |v|, plus 1; size 0 when v == 0. Amplitude = v if v > 0; (v + 2^size − 1) masked to size bits if v < 0.
- DC (index 0):
  - diff = coef_in − pred[coef_channel], computed in COEF_WIDTH+1 bits, no overflow.
  - Always emits one symbol: run 0, sym_is_dc 1; size 0 is legal.
  - pred[coef_channel] ← coef_in.
  - The channel is latched for the remainder of the block.
- AC (index 1..BLOCK_LEN−1), zero coefficient:
  - At index < BLOCK_LEN−1: zrun++, no symbol.
  - At index BLOCK_LEN−1: emit EOB (run 0, size 0, sym_last 1); pending ZRLs are discarded.
- AC nonzero:
  - If zrun ≥ 16: capture the coefficient in a hold register, enter S_ZRL, emit floor(zrun/16) ZRL symbols (run 15, size 0).
  - Then emit the coefficient with run = zrun mod 16.
  - Clear zrun.
  - sym_last = 1 when index == BLOCK_LEN−1; no EOB follows.
- States:
  - S_DC: expecting index 0.
  - S_AC: accepting AC coefficients.
  - S_ZRL: input stalled, draining ZRLs plus the held symbol.
- Transitions:
  - S_DC → S_AC on DC accept.
  - S_AC → S_ZRL on nonzero accept with zrun ≥ 16.
  - S_ZRL → S_AC after the held symbol is loaded into the output register.
  - Any state → S_DC after the last symbol of the block is loaded, or at index wrap.
- restart: all predictors ← 0 at the clock edge.
  - Coincident with a DC accept: that DC uses pred = 0, and its own coef_in is then stored.
  - Mid-block: the block continues unaffected.
- reset mid-block: the block is abandoned; the next accepted coefficient is DC.

## Timing
- Output is a single registered stage. Latency is 1 cycle from the accepting edge to sym_valid for a non-stalling symbol.
- coef_ready = (state != S_ZRL) && (!sym_valid || sym_ready). It has no combinational dependence on coef_valid or coef_in.
- The symbol fields hold steady while sym_valid && !sym_ready.
- Zero-coefficient accepts that produce no symbol can complete back-to-back regardless of sym_ready, provided coef_ready is high.
- In S_ZRL, one ZRL is loaded per cycle in which the output register is empty or draining. A run of 47 zeros costs 2 stall cycles beyond the symbol itself.
- Sustained throughput is 1 coefficient per cycle with sym_ready held at 1.
- Reset values:
  - sym_valid 0; sym_run, sym_size, sym_amplitude, sym_is_dc and sym_last all 0.
  - coef_ready 1.
  - State S_DC, index 0, zrun 0, all predictors 0.

## Structure
- Package coef_rle_pkg holds: ZRL_RUN = 15, EOB symbol constants, and the state encoding (S_DC, S_AC, S_ZRL).
- Sub-module magnitude_category:
  - Purely combinational, parametrised by width.
  - Maps a signed value to (size, amplitude).
  - Instantiated once on the muxed DC-diff/AC path.
- Predictors live in a NUM_CHANNELS × COEF_WIDTH register array inside the top module.

## Test plan
- DC sequence 100, 95, 95 on channel 0 → diffs 100, −5, 0: (size 7, amp 100), (size 3, amp 2), (size 0). Each block is otherwise all-zero and is followed by EOB with sym_last 1.
- Interleaved channels 0/1/2 with DC 10/20/30 twice → second-pass diffs are all 0, proving predictors are independent.
- AC values −1 at index 1 and 7 at index 2, remainder zero → (0,1,amp 0), (0,3,amp 7), EOB.
- 40 zeros followed by 3 at index 41 → ZRL, ZRL, (run 8, size 2, amp 3); coef_ready low for 2 cycles.
- Nonzero at index 63 → symbol with sym_last 1 and no EOB. 30 zeros then end of block → EOB only, no ZRLs.
- Random sym_ready back-pressure, restart pulse coincident with a DC accept, and asynchronous reset at index 20 → fields stable under stall, DC diff equals coef_in, and the next coefficient is treated as DC. Compare against a golden T.81 model.
